// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ packet sources.
// Round-robin grant at packet boundaries, byte pacing on tx_done, and a
// minimum idle gap between packets.
// Optional build macro TX_CHKSUM_EN appends a two's-complement check byte to
// every completed packet.
//
// state | meaning
// IDLE  | count down the inter-packet gap, then pick the next round-robin owner
// SEND  | load the owner's byte, pulse trmt and byte_ack together
// WAIT  | hold tx_data/gnt until tx_done, then next byte, check byte or release
// CHK   | (TX_CHKSUM_EN only) send the check byte, no byte_ack
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy
);

  localparam int            IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDXW:0] NREQ     = (IDXW+1)'(NUM_REQ);
  localparam logic [15:0]   GAP_LOAD = 16'(GAP_CYCLES);

`ifdef TX_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, WAIT, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

  state_t             state, state_nx;
  logic [IDXW-1:0]    rr_ptr, rr_ptr_nx;
  logic [15:0]        gap, gap_nx;
  logic               last_q, last_nx;
  logic [NUM_REQ-1:0] gnt_nx, ack_nx;
  logic               trmt_nx, busy_nx;
  logic [7:0]         data_nx;

  logic [IDXW:0]      cand;
  logic [IDXW-1:0]    win;
  logic               win_vld;
  logic [7:0]         cur_data;
  logic               cur_last, cur_req;

`ifdef TX_CHKSUM_EN
  logic [7:0]         chk, chk_nx;
  logic               chk_sent, chk_sent_nx;
`endif

  // Round-robin search starting just after the previous owner.
  always_comb begin
    cand    = '0;
    win     = rr_ptr;
    win_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_vld && req[cand[IDXW-1:0]]) begin
        win_vld = 1'b1;
        win     = cand[IDXW-1:0];
      end
    end
  end

  // Select the current owner's byte, last flag and request.
  always_comb begin
    cur_data = 8'h00;
    cur_last = 1'b0;
    cur_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_ptr == IDXW'(i)) begin
        cur_data = req_data[8*i +: 8];
        cur_last = req_last[i];
        cur_req  = req[i];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    gap_nx    = gap;
    last_nx   = last_q;
    gnt_nx    = gnt;
    ack_nx    = '0;
    trmt_nx   = 1'b0;
    data_nx   = tx_data;
`ifdef TX_CHKSUM_EN
    chk_nx      = chk;
    chk_sent_nx = chk_sent;
`endif
    case (state)
      IDLE: begin
        if (gap != 16'd0) begin
          gap_nx = gap - 16'd1;
        end else if (win_vld) begin
          gnt_nx    = NUM_REQ'(1) << win;
          rr_ptr_nx = win;
          state_nx  = SEND;
`ifdef TX_CHKSUM_EN
          chk_nx      = 8'h00;
          chk_sent_nx = 1'b0;
`endif
        end
      end
      SEND: begin
        data_nx  = cur_data;
        last_nx  = cur_last;
        trmt_nx  = 1'b1;
        ack_nx   = NUM_REQ'(1) << rr_ptr;
        state_nx = WAIT;
`ifdef TX_CHKSUM_EN
        chk_nx = chk + cur_data;
`endif
      end
      WAIT: begin
        if (tx_done) begin
          if (!last_q && cur_req) begin
            state_nx = SEND;
`ifdef TX_CHKSUM_EN
          end else if (last_q && !chk_sent) begin
            state_nx = CHK;
`endif
          end else begin
            // Packet finished or source withdrew mid-packet: release the UART.
            gnt_nx   = '0;
            gap_nx   = GAP_LOAD;
            state_nx = IDLE;
          end
        end
      end
`ifdef TX_CHKSUM_EN
      CHK: begin
        data_nx     = (~chk) + 8'd1;
        trmt_nx     = 1'b1;
        chk_sent_nx = 1'b1;
        state_nx    = WAIT;
      end
`endif
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE) || (gap_nx != 16'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gap      <= '0;
      last_q   <= 1'b0;
      gnt      <= '0;
      byte_ack <= '0;
      trmt     <= 1'b0;
      tx_data  <= 8'hFF;
      busy     <= 1'b0;
`ifdef TX_CHKSUM_EN
      chk      <= 8'h00;
      chk_sent <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      gap      <= gap_nx;
      last_q   <= last_nx;
      gnt      <= gnt_nx;
      byte_ack <= ack_nx;
      trmt     <= trmt_nx;
      tx_data  <= data_nx;
      busy     <= busy_nx;
`ifdef TX_CHKSUM_EN
      chk      <= chk_nx;
      chk_sent <= chk_sent_nx;
`endif
    end
  end

endmodule
